atriusb_event_readout_mc: RTL and testbench
===========================================

Name: atriusb_event_readout_mc

Overview:
- Next-generation event readout: drains framed event data from NUM_CH byte-wide first-word-fall-through (FWFT) event FIFOs and pushes it to the v4-style USB bridge in packets of at most MAX_PKT_BYTES.
- Generalises the single-FIFO readout with:
  - parametrised channel count and packet size;
  - round-robin channel arbitration at frame boundaries;
  - correct handling of 0-, 1- and 2-byte tail packets;
  - a real per-byte valid strobe.
- Sits between the per-channel event FIFOs (already in the phy clock domain) and the bridge arbiter.

Parameters:
- NUM_CH, 2, number of source event FIFOs (1..8).
- MAX_PKT_BYTES, 512, maximum bytes per bridge grant (power of 2, 8..1024).
- CNT_W, 17, width of FIFO byte-count inputs.

Ports:
- phy_clk_i  in  1  sole clock.
- rst_i  in  1  asynchronous, active-high reset.
- fifo_dat_i  in  8*NUM_CH  FWFT data, channel c at [8c+:8].
- fifo_count_i  in  CNT_W*NUM_CH  bytes available per channel.
- fifo_rd_o  in/out: out  NUM_CH  one-hot read strobe (pop current byte).
- bridge_dat_o  out  8  byte to bridge.
- bridge_valid_o  out  1  bridge_dat_o valid this cycle.
- bridge_request_o  out  1  request bridge access.
- bridge_grant_i  in  1  access granted.
- bridge_end_o  out  1  coincident with last byte of a frame.
- active_ch_o  out  3  channel currently being read.
- busy_o  out  1  frame in progress.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0.
- Reset mid-frame aborts immediately; no bridge_end_o is issued.
- Frame format:
  - 4 header bytes: type, number, LEN_MSB, LEN_LSB.
  - LEN counts 16-bit words; payload = 2*LEN bytes; total frame = 4 + 2*LEN bytes.
- IDLE:
  - Scan channels round-robin starting at ptr+1 (after reset: from ch0).
  - The first channel with count >= 4 is latched as active → HDR.
- HDR (4 cycles):
  - Pop 4 bytes into registers; fifo_rd_o is high for those 4 cycles.
  - remaining := 2*LEN (17 bits); hdr_pending := 1 → WAIT_DATA.
- WAIT_DATA:
  - need = min(remaining, MAX_PKT_BYTES − 4*hdr_pending).
  - When count[active] >= need → REQ.
  - need == 0 (LEN=0) counts as satisfied.
- REQ: bridge_request_o = 1; stays asserted until the packet's last byte.
- GRANT→XFER:
  - The cycle after bridge_grant_i is seen high, the first byte is presented with bridge_valid_o = 1.
  - One byte per cycle, no gaps.
  - If hdr_pending: 4 header bytes are sent first, then payload.
  - Each payload byte pops the FIFO in the same cycle it is presented (FWFT, no priming read).
  - remaining decrements per payload byte; pkt_cnt increments per byte sent.
- Packet end: when pkt_cnt reaches MAX_PKT_BYTES or remaining reaches 0:
  - deassert request next cycle; hdr_pending := 0.
  - If remaining > 0 → WAIT_DATA.
  - Else assert bridge_end_o on the final byte, set ptr := active → IDLE.
- bridge_end_o is also asserted on an exactly-full final packet.
- LEN=0: header-only packet, bridge_end_o on byte 4.
- Frame of 508 payload bytes fits one 512-byte packet; 510 payload bytes spills 2 bytes into a second packet.
- Grant dropping mid-packet is a protocol violation; the block ignores grant after the first cycle.
- fifo_rd_o is never asserted when count[active] == 0 (assertion).

Optional Feature:
- READOUT_STATS_EN defined:
  - adds output frames_o[31:0] (completed frames, wraps) and bytes_o[31:0] (bytes sent, wraps);
  - both cleared by rst_i.
- Undefined: ports absent, no counters.

Decomposition:
- Package atriusb_readout_pkg:
  - state enum (IDLE, HDR, WAIT_DATA, REQ, XFER);
  - HDR_BYTES = 4;
  - min-helper function.
- One sub-module: atriusb_rr_arbiter (NUM_CH request vector + pointer → one-hot grant + index), combinational with registered pointer owned by the parent.

Test Plan:
- ch0 frame LEN=2, count=8, grant 3 cycles after request → 8 bytes with valid contiguous, bridge_end_o on byte 8, 8 pops.
- ch1 frame LEN=300 (600 payload), data fully present → packet 1 = 512 bytes (header + 508), request drops, packet 2 = 92 bytes with bridge_end_o on last.
- LEN=0 → single 4-byte packet, bridge_end_o on 4th byte, no payload pops.
- Both channels holding frames continuously → frames alternate ch0, ch1, ch0; active_ch_o tracks.
- Payload trickles in (count below need) → no request until count >= need; no underflow pops.
- rst_i asserted mid-XFER at byte 100 → all outputs 0 asynchronously; next frame from a fresh header is read cleanly.

Source files
------------

// File: rtl/atriusb_readout_pkg.sv
// Shared types and helpers for the multi-channel event readout.
package atriusb_readout_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWaitData,
        StReq,
        StXfer
    } state_e;

    localparam int unsigned HDR_BYTES = 4;

    function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/atriusb_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after start.
module atriusb_rr_arbiter #(
    parameter int unsigned NUM_CH = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [2:0]        start,
    output logic [NUM_CH-1:0] gnt,
    output logic [2:0]        idx,
    output logic              any
);

    logic [7:0]  req8;
    logic [7:0]  gnt8;
    logic [31:0] c;

    always_comb begin
        req8 = 8'(req);
        gnt8 = '0;
        idx  = '0;
        any  = 1'b0;
        c    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            c = (32'(start) + i) % NUM_CH;
            if (!any && req8[c[2:0]]) begin
                any           = 1'b1;
                gnt8[c[2:0]]  = 1'b1;
                idx           = c[2:0];
            end
        end
        gnt = gnt8[NUM_CH-1:0];
    end

endmodule

// File: rtl/atriusb_event_readout_mc.sv
// Drains framed events from NUM_CH FWFT FIFOs into bridge packets of at most MAX_PKT_BYTES.
// Optional frame/byte counters are enabled with READOUT_STATS_EN.
module atriusb_event_readout_mc
    import atriusb_readout_pkg::*;
#(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned MAX_PKT_BYTES = 512,
    parameter int unsigned CNT_W         = 17
) (
    input  logic                    phy_clk_i,
    input  logic                    rst_i,
    input  logic [8*NUM_CH-1:0]     fifo_dat_i,
    input  logic [CNT_W*NUM_CH-1:0] fifo_count_i,
    output logic [NUM_CH-1:0]       fifo_rd_o,
    output logic [7:0]              bridge_dat_o,
    output logic                    bridge_valid_o,
    output logic                    bridge_request_o,
    input  logic                    bridge_grant_i,
    output logic                    bridge_end_o,
    output logic [2:0]              active_ch_o,
`ifdef READOUT_STATS_EN
    output logic [31:0]             frames_o,
    output logic [31:0]             bytes_o,
`endif
    output logic                    busy_o
);

    localparam int unsigned PW = $clog2(MAX_PKT_BYTES) + 1;

    state_e          state_q, state_d;
    logic [2:0]      active_q, active_d, ptr_q, ptr_d;
    logic            started_q, started_d, hdr_pending_q, hdr_pending_d;
    logic [3:0][7:0] hdr_q, hdr_d;
    logic [1:0]      hdr_idx_q, hdr_idx_d;
    logic [16:0]     remaining_q, remaining_d, rem_after, need, room;
    logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic            is_hdr;
    logic [7:0]      rd8;

    logic [CNT_W-1:0] cnt_arr [8];
    logic [7:0]       dat_arr [8];
    logic [NUM_CH-1:0] avail, arb_gnt;
    logic [2:0]       arb_idx, arb_start;
    logic             arb_any;

    for (genvar c = 0; c < 8; c++) begin : g_unpack
        if (c < NUM_CH) begin : g_ch
            assign cnt_arr[c] = fifo_count_i[CNT_W*c +: CNT_W];
            assign dat_arr[c] = fifo_dat_i[8*c +: 8];
            assign avail[c]   = 32'(cnt_arr[c]) >= HDR_BYTES;
        end else begin : g_pad
            assign cnt_arr[c] = '0;
            assign dat_arr[c] = '0;
        end
    end

    // Until the first frame completes, scanning starts at channel 0.
    assign arb_start = !started_q ? 3'd0 :
                       (ptr_q == 3'(NUM_CH - 1)) ? 3'd0 : ptr_q + 3'd1;

    atriusb_rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .req  (avail),
        .start(arb_start),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    assign room = hdr_pending_q ? 17'(MAX_PKT_BYTES - HDR_BYTES) : 17'(MAX_PKT_BYTES);
    assign need = min17(remaining_q, room);

    always_comb begin
        state_d          = state_q;
        active_d         = active_q;
        ptr_d            = ptr_q;
        started_d        = started_q;
        hdr_d            = hdr_q;
        hdr_idx_d        = hdr_idx_q;
        remaining_d      = remaining_q;
        hdr_pending_d    = hdr_pending_q;
        pkt_cnt_d        = pkt_cnt_q;
        rd8              = '0;
        bridge_dat_o     = '0;
        bridge_valid_o   = 1'b0;
        bridge_request_o = 1'b0;
        bridge_end_o     = 1'b0;
        is_hdr           = 1'b0;
        rem_after        = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    active_d  = arb_idx;
                    hdr_idx_d = '0;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                rd8[active_q]        = 1'b1;
                hdr_d[hdr_idx_q]     = dat_arr[active_q];
                hdr_idx_d            = hdr_idx_q + 2'd1;
                if (hdr_idx_q == 2'd3) begin
                    remaining_d   = {hdr_q[2], dat_arr[active_q], 1'b0};
                    hdr_pending_d = 1'b1;
                    state_d       = StWaitData;
                end
            end
            StWaitData: begin
                pkt_cnt_d = '0;
                if (32'(cnt_arr[active_q]) >= 32'(need)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                bridge_request_o = 1'b1;
                if (bridge_grant_i) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                bridge_request_o = 1'b1;
                bridge_valid_o   = 1'b1;
                pkt_cnt_d        = pkt_cnt_q + 1'b1;
                is_hdr           = hdr_pending_q && (pkt_cnt_q < PW'(HDR_BYTES));
                if (is_hdr) begin
                    bridge_dat_o = hdr_q[pkt_cnt_q[1:0]];
                end else begin
                    bridge_dat_o  = dat_arr[active_q];
                    rd8[active_q] = 1'b1;
                    rem_after     = remaining_q - 17'd1;
                    remaining_d   = rem_after;
                end
                // A header byte can only close the packet when it is the last header byte.
                if ((pkt_cnt_q == PW'(MAX_PKT_BYTES - 1)) ||
                    ((rem_after == '0) && (!is_hdr || pkt_cnt_q == PW'(HDR_BYTES - 1)))) begin
                    hdr_pending_d = 1'b0;
                    if (rem_after != '0) begin
                        state_d = StWaitData;
                    end else begin
                        bridge_end_o = 1'b1;
                        ptr_d        = active_q;
                        started_d    = 1'b1;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        fifo_rd_o = rd8[NUM_CH-1:0];
    end

    always_ff @(posedge phy_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            active_q      <= '0;
            ptr_q         <= '0;
            started_q     <= 1'b0;
            hdr_q         <= '0;
            hdr_idx_q     <= '0;
            remaining_q   <= '0;
            hdr_pending_q <= 1'b0;
            pkt_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            ptr_q         <= ptr_d;
            started_q     <= started_d;
            hdr_q         <= hdr_d;
            hdr_idx_q     <= hdr_idx_d;
            remaining_q   <= remaining_d;
            hdr_pending_q <= hdr_pending_d;
            pkt_cnt_q     <= pkt_cnt_d;
        end
    end

    assign active_ch_o = active_q;
    assign busy_o      = (state_q != StIdle);

`ifdef READOUT_STATS_EN
    logic [31:0] frames_q, bytes_q;

    always_ff @(posedge phy_clk_i or posedge rst_i) begin
        if (rst_i) begin
            frames_q <= '0;
            bytes_q  <= '0;
        end else begin
            if (bridge_end_o) frames_q <= frames_q + 32'd1;
            if (bridge_valid_o) bytes_q <= bytes_q + 32'd1;
        end
    end

    assign frames_o = frames_q;
    assign bytes_o  = bytes_q;
`endif

    rd_not_empty: assert property (@(posedge phy_clk_i) disable iff (rst_i)
        (|fifo_rd_o) |-> (cnt_arr[active_q] != '0));

    arb_onehot: assert property (@(posedge phy_clk_i) disable iff (rst_i) $onehot0(arb_gnt));

endmodule

// File: tb/tb_atriusb_event_readout_mc.sv
// Directed bench for atriusb_event_readout_mc with two modelled FWFT FIFOs.
module tb_atriusb_event_readout_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fifo_dat;
    logic [33:0] fifo_count;
    logic [1:0]  fifo_rd;
    logic [7:0]  bridge_dat;
    logic        bridge_valid, bridge_request, bridge_grant, bridge_end, busy;
    logic [2:0]  active_ch;
`ifdef READOUT_STATS_EN
    logic [31:0] frames, bytes_sent;
`endif

    always #5 clk = ~clk;

    atriusb_event_readout_mc #(
        .NUM_CH(2),
        .MAX_PKT_BYTES(512),
        .CNT_W(17)
    ) dut (
        .phy_clk_i       (clk),
        .rst_i           (rst),
        .fifo_dat_i      (fifo_dat),
        .fifo_count_i    (fifo_count),
        .fifo_rd_o       (fifo_rd),
        .bridge_dat_o    (bridge_dat),
        .bridge_valid_o  (bridge_valid),
        .bridge_request_o(bridge_request),
        .bridge_grant_i  (bridge_grant),
        .bridge_end_o    (bridge_end),
        .active_ch_o     (active_ch),
`ifdef READOUT_STATS_EN
        .frames_o        (frames),
        .bytes_o         (bytes_sent),
`endif
        .busy_o          (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fq0[$], fq1[$], pend[$], expq[$], got[$];
    int pkts[$], end_chs[$];
    int pops0, pops1, underflow, gaps, end_cnt, end_at, pkt_bytes, gdel;
    logic req_seen, valid_prev, req_prev;
    logic [1:0] rd_snap;

    typedef struct {
        int ch;
        int len;
        int gd;
        int exp_total;
        int exp_npkt;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint actual, input longint required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic refresh();
        fifo_dat[7:0]     = (fq0.size() != 0) ? fq0[0] : 8'h00;
        fifo_dat[15:8]    = (fq1.size() != 0) ? fq1[0] : 8'h00;
        fifo_count[16:0]  = 17'(fq0.size());
        fifo_count[33:17] = 17'(fq1.size());
    endtask

    task automatic build_frame(input int ch, input int num, input int len);
        logic [7:0] b;
        pend.delete();
        for (int k = 0; k < 4 + 2 * len; k++) begin
            case (k)
                0:       b = 8'(32'hE0 + ch);
                1:       b = 8'(num);
                2:       b = 8'(len >> 8);
                3:       b = 8'(len);
                default: b = 8'(k * 13 + ch * 5 + num);
            endcase
            pend.push_back(b);
            expq.push_back(b);
        end
    endtask

    task automatic push_n(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            if (ch == 0) fq0.push_back(pend.pop_front());
            else fq1.push_back(pend.pop_front());
        end
        refresh();
    endtask

    task automatic clear_cap();
        got.delete();
        expq.delete();
        pkts.delete();
        end_chs.delete();
        pops0 = 0; pops1 = 0; underflow = 0; gaps = 0;
        end_cnt = 0; end_at = 0; pkt_bytes = 0; req_seen = 1'b0;
    endtask

    task automatic wait_end(input string name, input int n, input int limit);
        int k = 0;
        while (end_cnt < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({name, "_end_seen"}, (end_cnt >= n) ? 1 : 0, 1);
    endtask

    function automatic int mismatches();
        int m = 0;
        for (int k = 0; k < expq.size(); k++) begin
            if (k >= got.size() || got[k] !== expq[k]) m++;
        end
        if (got.size() > expq.size()) m += got.size() - expq.size();
        return m;
    endfunction

    // Bridge monitor: sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        rd_snap = fifo_rd;
        if (rst) begin
            valid_prev = 1'b0;
            req_prev   = 1'b0;
            pkt_bytes  = 0;
        end else begin
            if (bridge_valid) begin
                if (!valid_prev && pkt_bytes != 0) gaps++;
                got.push_back(bridge_dat);
                pkt_bytes++;
            end
            if (bridge_end) begin
                end_cnt++;
                end_at = got.size();
                end_chs.push_back(int'(active_ch));
            end
            if (bridge_request) req_seen = 1'b1;
            if (req_prev && !bridge_request) begin
                pkts.push_back(pkt_bytes);
                pkt_bytes = 0;
            end
            valid_prev = bridge_valid;
            req_prev   = bridge_request;
        end
    end

    // FWFT FIFO model: pops land just after the edge that consumed the byte.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (rd_snap[0]) begin
                pops0++;
                if (fq0.size() == 0) underflow++;
                else void'(fq0.pop_front());
            end
            if (rd_snap[1]) begin
                pops1++;
                if (fq1.size() == 0) underflow++;
                else void'(fq1.pop_front());
            end
        end
        refresh();
    end

    initial begin
        bridge_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (bridge_request && !rst && !bridge_grant) begin
                repeat (gdel - 1) @(negedge clk);
                bridge_grant = 1'b1;
                @(negedge clk);
                bridge_grant = 1'b0;
                while (bridge_request) @(negedge clk);
            end
        end
    end

    initial begin
        vecs[0] = '{ch: 0, len: 2,   gd: 3, exp_total: 8,   exp_npkt: 1, exp_first: 8,   exp_last: 8};
        vecs[1] = '{ch: 1, len: 300, gd: 1, exp_total: 604, exp_npkt: 2, exp_first: 512, exp_last: 92};
        vecs[2] = '{ch: 0, len: 0,   gd: 2, exp_total: 4,   exp_npkt: 1, exp_first: 4,   exp_last: 4};
        vecs[3] = '{ch: 1, len: 254, gd: 2, exp_total: 512, exp_npkt: 1, exp_first: 512, exp_last: 512};
        vecs[4] = '{ch: 0, len: 255, gd: 4, exp_total: 514, exp_npkt: 2, exp_first: 512, exp_last: 2};
        vecs[5] = '{ch: 1, len: 256, gd: 1, exp_total: 516, exp_npkt: 2, exp_first: 512, exp_last: 4};

        rst = 1'b1;
        gdel = 2;
        clear_cap();
        refresh();
        repeat (3) @(negedge clk);
        check("rst_valid", bridge_valid, 0);
        check("rst_request", bridge_request, 0);
        check("rst_end", bridge_end, 0);
        check("rst_rd", fifo_rd, 0);
        check("rst_busy_active", {busy, active_ch, bridge_dat}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            string p;
            p = $sformatf("v%0d", i);
            clear_cap();
            gdel = vecs[i].gd;
            build_frame(vecs[i].ch, i, vecs[i].len);
            push_n(vecs[i].ch, pend.size());
            wait_end(p, 1, 3000);
            repeat (4) @(negedge clk);
            check({p, "_total"}, got.size(), vecs[i].exp_total);
            check({p, "_data_mism"}, mismatches(), 0);
            check({p, "_npkt"}, pkts.size(), vecs[i].exp_npkt);
            check({p, "_first_pkt"}, (pkts.size() > 0) ? pkts[0] : -1, vecs[i].exp_first);
            check({p, "_last_pkt"}, (pkts.size() > 0) ? pkts[pkts.size()-1] : -1,
                  vecs[i].exp_last);
            check({p, "_end_cnt"}, end_cnt, 1);
            check({p, "_end_at"}, end_at, vecs[i].exp_total);
            check({p, "_pops"}, (vecs[i].ch == 0) ? pops0 : pops1, vecs[i].exp_total);
            check({p, "_end_ch"}, (end_chs.size() > 0) ? end_chs[0] : -1, vecs[i].ch);
            check({p, "_gaps"}, gaps, 0);
            check({p, "_underflow"}, underflow, 0);
            check({p, "_busy_after"}, busy, 0);
        end

        // Both channels loaded from reset: frames must alternate ch0, ch1, ch0, ch1.
        rst = 1'b1;
        @(negedge clk);
        fq0.delete();
        fq1.delete();
        clear_cap();
        gdel = 2;
        build_frame(0, 20, 1); push_n(0, pend.size());
        build_frame(1, 21, 2); push_n(1, pend.size());
        build_frame(0, 22, 3); push_n(0, pend.size());
        build_frame(1, 23, 1); push_n(1, pend.size());
        @(negedge clk);
        rst = 1'b0;
        wait_end("rr", 4, 2000);
        repeat (4) @(negedge clk);
        check("rr_data_mism", mismatches(), 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_end_ch%0d", k), (end_chs.size() > k) ? end_chs[k] : -1, k % 2);
        end
        check("rr_underflow", underflow, 0);

        // Payload trickles in: no request until the whole 20-byte packet is present.
        clear_cap();
        build_frame(0, 30, 10);
        push_n(0, 9);
        repeat (40) @(negedge clk);
        check("trk_no_request", req_seen, 0);
        check("trk_busy", busy, 1);
        check("trk_hdr_pops", pops0, 4);
        push_n(0, pend.size());
        wait_end("trk", 1, 500);
        repeat (4) @(negedge clk);
        check("trk_data_mism", mismatches(), 0);
        check("trk_end_at", end_at, 24);
        check("trk_underflow", underflow, 0);

        // Asynchronous reset partway through a long packet.
        clear_cap();
        gdel = 1;
        build_frame(1, 40, 300);
        push_n(1, pend.size());
        begin
            int k = 0;
            while (got.size() < 100 && k < 2000) begin
                @(negedge clk);
                k++;
            end
            check("rst_mid_reached", (got.size() >= 100) ? 1 : 0, 1);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", bridge_valid, 0);
        check("rst_mid_request", bridge_request, 0);
        check("rst_mid_rd", fifo_rd, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_misc", {bridge_end, active_ch, bridge_dat}, 0);
        check("rst_mid_no_end", end_cnt, 0);
        fq0.delete();
        fq1.delete();
        pend.delete();
        refresh();
        @(negedge clk);
        clear_cap();
        build_frame(0, 41, 3);
        push_n(0, pend.size());
        @(negedge clk);
        rst = 1'b0;
        wait_end("post", 1, 500);
        repeat (4) @(negedge clk);
        check("post_data_mism", mismatches(), 0);
        check("post_end_at", end_at, 10);
        check("post_end_ch", (end_chs.size() > 0) ? end_chs[0] : -1, 0);
        check("post_underflow", underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
